urv_writeback: RTL

URV_WRITEBACK -- requirements
Module: urv_writeback

---
 rtl/urv_writeback.sv | 134 +++++++++++++
 1 files changed

// File: rtl/urv_writeback.sv
// Writeback stage: commits execute results and aligned load data to the register file,
// stalling upstream while a load waits for its data word, with an optional load timeout.
module urv_writeback #(
  parameter int g_load_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_kill_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        w_load_fault_o
);

  localparam int CW = (g_load_timeout < 2) ? 1 : $clog2(g_load_timeout + 1);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    ld_rd_q;
  logic          ld_rd_write_q;
  logic [2:0]    ld_fun_q;
  logic [1:0]    ld_off_q;

  logic          rf_write_q;
  logic [4:0]    rf_rd_q;
  logic [31:0]   rf_value_q;
  logic          fault_q;

  logic          accept;
  logic          timeout_hit;
  logic          commit_we;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_value_d;

  assign w_stall_req_o  = (state_q == S_WAIT_LOAD);
  assign accept         = x_valid_i && !x_kill_i && !w_stall_req_o;
  // Counter holds the number of completed wait cycles; the last allowed cycle is limit-1.
  assign timeout_hit    = (g_load_timeout != 0) && (cnt_q == CW'(g_load_timeout - 1));
  assign commit_we      = ld_rd_write_q && (ld_rd_q != 5'd0);

  assign rf_rd_write_o  = rf_write_q;
  assign rf_rd_o        = rf_rd_q;
  assign rf_rd_value_o  = rf_value_q;
  assign w_load_fault_o = fault_q;

  always_comb begin
    byte_sel = 8'h00;
    case (ld_off_q)
      2'd0:    byte_sel = dm_data_l_i[7:0];
      2'd1:    byte_sel = dm_data_l_i[15:8];
      2'd2:    byte_sel = dm_data_l_i[23:16];
      default: byte_sel = dm_data_l_i[31:24];
    endcase
    half_sel = ld_off_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

    load_value_d = dm_data_l_i;
    case (ld_fun_q)
      3'b000:  load_value_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_value_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_value_d = {24'h000000, byte_sel};
      3'b101:  load_value_d = {16'h0000, half_sel};
      default: load_value_d = dm_data_l_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ld_rd_q       <= 5'd0;
      ld_rd_write_q <= 1'b0;
      ld_fun_q      <= 3'd0;
      ld_off_q      <= 2'd0;
      rf_write_q    <= 1'b0;
      rf_rd_q       <= 5'd0;
      rf_value_q    <= 32'd0;
      fault_q       <= 1'b0;
    end else begin
      rf_write_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (x_load_i) begin
              state_q       <= S_WAIT_LOAD;
              cnt_q         <= '0;
              ld_rd_q       <= x_rd_i;
              ld_rd_write_q <= x_rd_write_i;
              ld_fun_q      <= x_fun_i;
              ld_off_q      <= x_dm_addr_i;
            end else if (x_rd_write_i && (x_rd_i != 5'd0)) begin
              rf_write_q <= 1'b1;
              rf_rd_q    <= x_rd_i;
              rf_value_q <= x_rd_value_i;
            end
          end
        end
        S_WAIT_LOAD: begin
          if (dm_load_done_i) begin
            state_q <= S_IDLE;
            if (commit_we) begin
              rf_write_q <= 1'b1;
              rf_rd_q    <= ld_rd_q;
              rf_value_q <= load_value_d;
            end
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
